tx_fifo: RTL and testbench
==========================

# tx_fifo

Byte buffer and pacing stage sitting directly upstream of the UART transmitter. It accepts bytes from the producer (message sequencer, CPU port) at full clock rate into a circular FIFO. It then drains them one at a time into the transmitter's `data_in`/`wr_en` port. It paces itself on the transmitter's `tx_busy` and `tx_clk` so that no byte is ever offered while the transmitter would ignore it.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2**DEPTH_LOG2 entries (legal range 1..8).
- `clk`  in  1  system clock, shared with the transmitter.
- `rst`  in  1  reset; asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe, one byte per cycle.
- `full`  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `tx_data`  out  8  byte presented to transmitter `data_in`.
- `tx_wr_en`  out  1  single-cycle write strobe to transmitter `wr_en`.
- `tx_busy`  in  1  transmitter busy (high in start/data states only).
- `tx_clk`  in  1  baud-rate single-cycle tick, the same one the transmitter uses.

## Operation
- Push: accepted iff `wr_en && !full`. Data is written at `wr_ptr`, and `wr_ptr` increments mod depth. A push while full is dropped silently and leaves `count` unchanged.
- Pop: happens only on the IDLE->LOAD transition. `tx_data <= mem[rd_ptr]` and `rd_ptr` increments mod depth.
- Simultaneous push and pop: both take effect and `count` is unchanged. When full, the push is still dropped even if a pop occurs in the same cycle.
- Pointers are DEPTH_LOG2 bits and wrap naturally. `count` is a separate up/down counter. `full = (count == 2**DEPTH_LOG2)` and `empty = (count == 0)`, both registered consistently with `count`.
- Drain FSM states and transitions:
  - IDLE: if `!empty`, pop, set `tx_wr_en <= 1`, go to LOAD.
  - LOAD: `tx_wr_en <= 0`, go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy`, go to WAIT_DONE.
  - WAIT_DONE: if `!tx_busy`, go to WAIT_STOP. The transmitter is now in its stop state.
  - WAIT_STOP: if `tx_clk`, go to IDLE. The transmitter returns to idle on the same edge.
- Reset state is WAIT_DONE, not IDLE. The transmitter has no reset, so a frame may still be in flight. This state resynchronises to it, at a cost of at most one bit period when the transmitter is already idle.
- `tx_data` holds the last popped byte until the next pop.

## Timing
- Reset values: `tx_wr_en=0`, `tx_data=8'h00`, `full=0`, `empty=1`, `count=0`, FSM=WAIT_DONE. Pointers are 0.
- Reset mid-operation: FIFO contents are discarded. Any in-flight transmitter frame completes unaffected.
- Write-to-`count`/`full`/`empty` latency is 1 cycle.
- Push into an empty FIFO with FSM in IDLE:
  - `tx_wr_en` high 2 cycles after the `wr_en` cycle (cycle N+1 `empty=0`, IDLE pops at the N+1 edge, strobe visible in cycle N+2).
  - `tx_wr_en` is high for exactly 1 cycle.
- `tx_wr_en` is never asserted unless the transmitter is in its idle state in that cycle.
- Back-to-back bytes: consecutive frames are separated by exactly the transmitter's minimum gap. Next strobe = cycle after the stop-to-idle `tx_clk` + 1.
- A `tx_clk` pulse coincident with `tx_wr_en` is harmless. The transmitter starts on the following tick.

## Configuration
- `TX_FIFO_OVF_FLAG_EN` defined: adds output `overflow` (1 bit).
  - Set sticky on any dropped push (`wr_en && full`).
  - Cleared only by `rst`; reset value 0.
- Not defined: port absent, and dropped pushes are invisible.

## Structure
- Package `tx_fifo_pkg` holds:
  - the FSM state enum (IDLE, LOAD, WAIT_BUSY, WAIT_DONE, WAIT_STOP);
  - the default `DEPTH_LOG2` constant.
- Sub-module `tx_fifo_mem`: storage plus pointers and count, exposing push/pop/full/empty/count. The drain FSM stays in the top level.

## Test plan
- Push `8'h48` into an empty FIFO, with the transmitter model idle and `tx_clk` every 16 cycles:
  - `tx_wr_en` pulses once, 2 cycles later, with `tx_data=8'h48`;
  - the serial line carries 0, then 0x48 LSB-first, then 1.
- Burst-push "Hello World" (11 bytes) at 1/cycle with DEPTH_LOG2=4:
  - `count` peaks at 11;
  - all 11 bytes are transmitted in order, with no byte lost or duplicated;
  - `empty=1` at the end.
- Push 20 bytes at DEPTH_LOG2=4 with `tx_busy` forced high:
  - `full=1` after 16 pushes, `count=16`;
  - bytes 17..20 are dropped;
  - with `TX_FIFO_OVF_FLAG_EN`, `overflow=1`.
- Push while popping at occupancy 5: `count` stays 5 in that cycle, and the pointer wrap past entry 15 preserves order.
- Assert `rst` mid-frame with 3 bytes queued:
  - outputs return to their reset values and the queue is empty;
  - no `tx_wr_en` occurs until the transmitter's stop-to-idle `tx_clk`;
  - the in-flight frame is intact.

Source files
------------

// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared types and constants for the UART transmit FIFO.
//   DEPTH_LOG2_DEF : default log2 of the FIFO depth
//   drain_st_e     : drain FSM states
package tx_fifo_pkg;

  localparam int DEPTH_LOG2_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    WAIT_STOP
  } drain_st_e;

endpackage

// File: rtl/tx_fifo_if.sv
// tx_fifo_if: producer-side enqueue port plus transmitter-side pacing port.
//   wr_data/wr_en          : byte enqueue (producer -> fifo)
//   full/empty/count       : occupancy status (fifo -> producer)
//   tx_data/tx_wr_en       : byte + strobe to transmitter data_in/wr_en
//   tx_busy/tx_clk         : transmitter busy flag and baud tick
//   overflow               : sticky dropped-push flag, only with TX_FIFO_OVF_FLAG_EN
// Modports: master = producer/transmitter side, slave = tx_fifo.
interface tx_fifo_if
  import tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic [7:0]          tx_data;
  logic                tx_wr_en;
  logic                tx_busy;
  logic                tx_clk;
`ifdef TX_FIFO_OVF_FLAG_EN
  logic                overflow;
`endif

  modport master (
    output wr_data, wr_en, tx_busy, tx_clk,
`ifdef TX_FIFO_OVF_FLAG_EN
    input  overflow,
`endif
    input  full, empty, count, tx_data, tx_wr_en
  );

  modport slave (
    input  wr_data, wr_en, tx_busy, tx_clk,
`ifdef TX_FIFO_OVF_FLAG_EN
    output overflow,
`endif
    output full, empty, count, tx_data, tx_wr_en
  );
endinterface

// File: rtl/tx_fifo_mem.sv
// tx_fifo_mem: circular byte store with read/write pointers and occupancy counter.
//   clk, rst    : clock, async active-high reset
//   push_i      : enqueue request (ignored while full)
//   pop_i       : dequeue request (ignored while empty)
//   wr_data_i   : byte to enqueue
//   rd_data_o   : byte at the read pointer (combinational)
//   full_o/empty_o/count_o : registered occupancy status
module tx_fifo_mem
  import tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [7:0]          wr_data_i,
  output logic [7:0]          rd_data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  push_ok, pop_ok;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // full/empty are registered from count_d so they always agree with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: contents are only reachable through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;
endmodule

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO that drains into a UART transmitter, paced on tx_busy/tx_clk
// so a byte is only offered while the transmitter is idle.
//   clk, rst : clock, async active-high reset
//   bus      : tx_fifo_if.slave (enqueue port, status, transmitter port)
// Optional: define TX_FIFO_OVF_FLAG_EN to add the sticky bus.overflow output.
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic      clk,
  input  logic      rst,
  tx_fifo_if.slave  bus
);
  drain_st_e           state_q, state_d;
  logic                pop;
  logic [7:0]          rd_data;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_wr_en_q, tx_wr_en_d;
  logic                full_w, empty_w;
  logic [DEPTH_LOG2:0] count_w;

  tx_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bus.wr_en),
    .pop_i     (pop),
    .wr_data_i (bus.wr_data),
    .rd_data_o (rd_data),
    .full_o    (full_w),
    .empty_o   (empty_w),
    .count_o   (count_w)
  );

  // WAIT_DONE/WAIT_STOP track the transmitter through stop->idle, which it
  // only leaves on a tx_clk tick; the next strobe follows that tick.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tx_wr_en_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: if (!empty_w) begin
        pop        = 1'b1;
        tx_wr_en_d = 1'b1;
        tx_data_d  = rd_data;
        state_d    = LOAD;
      end
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_d = WAIT_STOP;
      WAIT_STOP: if (bus.tx_clk)   state_d = IDLE;
      default:   state_d = WAIT_DONE;
    endcase
  end

  // Reset lands in WAIT_DONE: the transmitter is not reset and may still be
  // mid-frame, so wait for it to reach idle before offering anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_DONE;
      tx_wr_en_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_wr_en_q <= tx_wr_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef TX_FIFO_OVF_FLAG_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (bus.wr_en && full_w)   ovf_q <= 1'b1;
  end
  assign bus.overflow = ovf_q;
`endif

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_wr_en = tx_wr_en_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_w;
endmodule

// File: tb/tb_tx_fifo.sv
// tb_tx_fifo: directed bench for tx_fifo with a behavioural UART transmitter and
// a scoreboard; stimulus queues expected bytes, monitors pop and compare.
module tb_tx_fifo;
  localparam int DL2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();
  tx_fifo #(.DEPTH_LOG2(DL2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s @%0t", nm, $time);
  endtask

  // ---------------- transmitter model (no reset, like the real one) ----------
  typedef enum {M_IDLE, M_START, M_DATA, M_STOP} mst_t;
  mst_t       mst = M_IDLE;
  logic [7:0] mdat = 8'h00;
  int         mbit = 0;
  logic       line;
  logic [3:0] tcnt = 4'd0;
  logic       busy_force = 1'b0;
  logic [9:0] rxsh = 10'h3ff;
  logic       rx_done = 1'b0;

  always @(posedge clk) tcnt <= tcnt + 4'd1;
  assign bus.tx_clk  = (tcnt == 4'd15);
  assign bus.tx_busy = busy_force || (mst == M_START) || (mst == M_DATA);
  assign line = (mst == M_START) ? 1'b0 : (mst == M_DATA) ? mdat[mbit[2:0]] : 1'b1;

  always @(posedge clk) begin
    rx_done <= bus.tx_clk && (mst == M_STOP);
    if (bus.tx_clk && mst != M_IDLE) rxsh <= {line, rxsh[9:1]};
    case (mst)
      M_IDLE:  if (bus.tx_wr_en) begin mdat <= bus.tx_data; mst <= M_START; end
      M_START: if (bus.tx_clk) begin mst <= M_DATA; mbit <= 0; end
      M_DATA:  if (bus.tx_clk) begin
                 if (mbit == 7) mst <= M_STOP;
                 else mbit <= mbit + 1;
               end
      M_STOP:  if (bus.tx_clk) mst <= M_IDLE;
      default: mst <= M_IDLE;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];   // bytes expected on tx_data, in order
  logic [7:0] rxq[$];     // bytes strobed, expected on the serial line
  logic       prev_we = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_wr_en) begin
      if (prev_we) fail("strobe_longer_than_1_cycle");
      if (mst != M_IDLE) fail("strobe_while_tx_not_idle");
      if (exp_q.size() == 0) fail("unexpected_strobe");
      else chk("tx_data", int'(bus.tx_data), int'(exp_q.pop_front()));
      rxq.push_back(bus.tx_data);
    end
    prev_we = bus.tx_wr_en;
    if (rx_done) begin
      if (rxq.size() == 0) fail("unexpected_frame");
      else chk("serial_frame", int'(rxsh), int'({1'b1, rxq.pop_front(), 1'b0}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    bus.wr_data = b;
    bus.wr_en   = 1'b1;
    if (expect_it) exp_q.push_back(b);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drained(input int maxc, input string nm);
    int n = 0;
    while (!(exp_q.size() == 0 && rxq.size() == 0 && mst == M_IDLE && bus.empty)) begin
      @(negedge clk);
      n++;
      if (n > maxc) begin fail({nm, "_timeout"}); break; end
    end
  endtask

  string hw = "Hello World";
  int    peak;
  int    n;

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    // reset values
    chk("rst_tx_wr_en", int'(bus.tx_wr_en), 0);
    chk("rst_tx_data",  int'(bus.tx_data), 0);
    chk("rst_full",     int'(bus.full), 0);
    chk("rst_empty",    int'(bus.empty), 1);
    chk("rst_count",    int'(bus.count), 0);
`ifdef TX_FIFO_OVF_FLAG_EN
    chk("rst_overflow", int'(bus.overflow), 0);
`endif
    rst = 1'b0;
    repeat (40) @(negedge clk);  // FSM resyncs to the idle transmitter

    // single byte: strobe exactly 2 cycles after the push cycle
    bus.wr_data = 8'h48; bus.wr_en = 1'b1; exp_q.push_back(8'h48);
    @(negedge clk); bus.wr_en = 1'b0;
    chk("t1_we_n1", int'(bus.tx_wr_en), 0);
    chk("t1_count_n1", int'(bus.count), 1);
    chk("t1_empty_n1", int'(bus.empty), 0);
    @(negedge clk);
    chk("t1_we_n2", int'(bus.tx_wr_en), 1);
    chk("t1_data_n2", int'(bus.tx_data), 8'h48);

    // burst "Hello World" while 0x48 is in flight
    peak = 0;
    for (int i = 0; i < 11; i++) begin
      push_byte(hw[i], 1'b1);
      if (int'(bus.count) > peak) peak = int'(bus.count);
    end
    chk("hw_peak_count", peak, 11);
    wait_drained(4000, "hw_drain");
    chk("hw_empty", int'(bus.empty), 1);
    chk("hw_count", int'(bus.count), 0);

    // push coinciding with pop at occupancy 5; pointers wrap past entry 15
    push_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), 1'b1);
    chk("pp_count_5", int'(bus.count), 5);
    n = 0;
    while (!(bus.tx_clk && mst == M_STOP)) begin
      @(negedge clk); n++;
      if (n > 400) begin fail("pp_stop_tick_timeout"); break; end
    end
    @(negedge clk);                 // FSM in IDLE this cycle, pops at its end
    chk("pp_count_pre", int'(bus.count), 5);
    bus.wr_data = 8'h15; bus.wr_en = 1'b1; exp_q.push_back(8'h15);
    @(negedge clk); bus.wr_en = 1'b0;
    chk("pp_count_same", int'(bus.count), 5);
    chk("pp_strobe_gap", int'(bus.tx_wr_en), 1);
    wait_drained(3000, "pp_drain");

    // reset mid-frame with 3 bytes queued
    for (int i = 0; i < 4; i++) push_byte(8'hC1 + 8'(i), 1'b1);
    n = 0;
    while (mst != M_DATA) begin
      @(negedge clk); n++;
      if (n > 400) begin fail("rst_wait_data_timeout"); break; end
    end
    chk("mid_count_3", int'(bus.count), 3);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_full",  int'(bus.full), 0);
    chk("mid_rst_we",    int'(bus.tx_wr_en), 0);
    chk("mid_rst_data",  int'(bus.tx_data), 0);
    @(negedge clk); rst = 1'b0;
    push_byte(8'h5A, 1'b1);         // must wait for the in-flight frame to end
    wait_drained(1000, "mid_drain");

    // overfill with transmitter held busy from reset
    busy_force = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_byte(8'hA0 + 8'(i), i < 16);
      if (i == 15) begin
        chk("ovf_full_16", int'(bus.full), 1);
        chk("ovf_count_16", int'(bus.count), 16);
`ifdef TX_FIFO_OVF_FLAG_EN
        chk("ovf_flag_before", int'(bus.overflow), 0);
`endif
      end
    end
    chk("ovf_full_end", int'(bus.full), 1);
    chk("ovf_count_end", int'(bus.count), 16);
`ifdef TX_FIFO_OVF_FLAG_EN
    chk("ovf_flag_after", int'(bus.overflow), 1);
`endif
    busy_force = 1'b0;
    wait_drained(6000, "ovf_drain");
    chk("final_empty", int'(bus.empty), 1);
    chk("final_count", int'(bus.count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
